// File: rtl/punte_enigma_uart.sv
// punte_enigma_uart
// Buffered stream bridge: uart_rx -> input FIFO -> classifier -> Enigma core -> uart_tx.
// Bytes leave in the order they arrived. At most one byte is held past the FIFO.
//
// Ports:
//   clk, rst              system clock, async active-high reset
//   rx_byte, rx_done      byte and one-cycle strobe from uart_rx
//   core_valid_in,
//   core_char_in          one-cycle request and letter index (0-25) to the core
//   core_char_out,
//   core_valid_out        encrypted index and one-cycle strobe from the core
//   tx_start, tx_din      one-cycle start strobe and byte to uart_tx
//   tx_busy               uart_tx is shifting a byte
//   clr_status            synchronous clear of overflow / core_err (a set wins)
//   overflow              sticky: byte dropped because the FIFO was full
//   core_err              sticky: the core did not answer in time
//   fifo_level            FIFO occupancy
//   char_count            bytes handed to uart_tx, wrapping
//   last_rx               last received byte, kept even when it was dropped
//   bypass                (only with PUNTE_BYPASS_EN) letters skip the core
//
// Optional feature macro: PUNTE_BYPASS_EN adds the bypass input.
//
// FSM states:
//   state     | meaning
//   S_IDLE    | wait for FIFO data, pop one byte into hold
//   S_CLASS   | classify hold as letter / other
//   S_ISSUE   | core_valid_in high for this single cycle
//   S_WAIT    | wait for core_valid_out or timeout
//   S_SEND    | wait for tx_busy low, then strobe tx_start
//   S_TX_WAIT | wait for tx_busy to rise and fall (or 4 cycles with no rise)
module punte_enigma_uart #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ACCEPT_LOWER = 1,
  parameter int unsigned PASS_OTHER   = 1,
  parameter int unsigned CORE_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_done,
  output logic                     core_valid_in,
  output logic [4:0]               core_char_in,
  input  logic [4:0]               core_char_out,
  input  logic                     core_valid_out,
  output logic                     tx_start,
  output logic [7:0]               tx_din,
  input  logic                     tx_busy,
  input  logic                     clr_status,
  output logic                     overflow,
  output logic                     core_err,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         char_count,
  output logic [7:0]               last_rx
`ifdef PUNTE_BYPASS_EN
  ,
  input  logic                     bypass
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(CORE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASS,
    S_ISSUE,
    S_WAIT,
    S_SEND,
    S_TX_WAIT
  } state_t;

  state_t state;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          push;
  logic          pop;

  logic [7:0]    hold;
  logic          hold_lower;
  logic          is_upper;
  logic          is_lower;
  logic [4:0]    letter_idx;
  logic [TW-1:0] timer;
  logic [1:0]    tx_wait;
  logic          busy_seen;

  // Full is judged on the registered level, so a pop in the same cycle
  // never makes room for a push.
  assign full       = (level == LW'(DEPTH));
  assign push       = rx_done && !full;
  assign pop        = (state == S_IDLE) && (level != '0);
  assign fifo_level = level;

  always_comb begin
    is_upper   = (hold >= 8'h41) && (hold <= 8'h5A);
    is_lower   = (ACCEPT_LOWER != 0) && (hold >= 8'h61) && (hold <= 8'h7A);
    // 'A' and 'a' both have 5'b00001 in their low bits, so one subtract
    // serves both cases.
    letter_idx = hold[4:0] - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      last_rx  <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (rx_done) last_rx <= rx_byte;
      if (rx_done && full) overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      hold          <= 8'h00;
      hold_lower    <= 1'b0;
      core_valid_in <= 1'b0;
      core_char_in  <= 5'd0;
      timer         <= '0;
      tx_start      <= 1'b0;
      tx_din        <= 8'h00;
      tx_wait       <= 2'd0;
      busy_seen     <= 1'b0;
      char_count    <= '0;
      core_err      <= 1'b0;
    end else begin
      if (clr_status) core_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            hold  <= mem[rd_ptr];
            state <= S_CLASS;
          end
        end
        S_CLASS: begin
          hold_lower <= is_lower;
          if (is_upper || is_lower) begin
`ifdef PUNTE_BYPASS_EN
            if (bypass) begin
              tx_din <= hold;
              state  <= S_SEND;
            end else begin
              core_valid_in <= 1'b1;
              core_char_in  <= letter_idx;
              state         <= S_ISSUE;
            end
`else
            core_valid_in <= 1'b1;
            core_char_in  <= letter_idx;
            state         <= S_ISSUE;
`endif
          end else if (PASS_OTHER != 0) begin
            tx_din <= hold;
            state  <= S_SEND;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          // Down-counter: reaching zero with no answer means the core
          // missed its CORE_TIMEOUT-cycle window.
          core_valid_in <= 1'b0;
          timer         <= TW'(CORE_TIMEOUT - 1);
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (core_valid_out) begin
            tx_din <= {3'b000, core_char_out} + (hold_lower ? 8'h61 : 8'h41);
            state  <= S_SEND;
          end else if (timer == '0) begin
            tx_din   <= 8'h3F;
            core_err <= 1'b1;
            state    <= S_SEND;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_start  <= 1'b1;
            tx_wait   <= 2'd3;
            busy_seen <= 1'b0;
            state     <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          tx_start <= 1'b0;
          if (busy_seen) begin
            if (!tx_busy) begin
              char_count <= char_count + CNT_W'(1);
              state      <= S_IDLE;
            end
          end else if (tx_busy) begin
            busy_seen <= 1'b1;
          end else if (tx_wait == 2'd0) begin
            // Transmitter never acknowledged; count the byte as sent.
            char_count <= char_count + CNT_W'(1);
            state      <= S_IDLE;
          end else begin
            tx_wait <= tx_wait - 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_punte_enigma_uart.sv
`timescale 1ns/1ps
module tb_punte_enigma_uart;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_done_a, rx_done_b, rx_done_c;
  logic       clr_status;

  // DUT A: default parameters, with core and uart_tx models
  logic       civ_a;
  logic [4:0] cci_a;
  logic [4:0] cco_a = 5'd0;
  logic       cvo_a = 1'b0;
  logic       txs_a;
  logic [7:0] txd_a;
  logic       txb_a;
  logic       ovf_a, cerr_a;
  logic [4:0] lvl_a;
  logic [15:0] cnt_a;
  logic [7:0] last_a;

  // DUT B: ACCEPT_LOWER=0, silent core, transmitter never busy
  logic       civ_b, txs_b, ovf_b, cerr_b;
  logic [4:0] cci_b, lvl_b;
  logic [7:0] txd_b, last_b;
  logic [15:0] cnt_b;

  // DUT C: PASS_OTHER=0
  logic       civ_c, txs_c, ovf_c, cerr_c;
  logic [4:0] cci_c, lvl_c;
  logic [7:0] txd_c, last_c;
  logic [15:0] cnt_c;

  int errors = 0;
  int checks = 0;

  punte_enigma_uart dut_a (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_done(rx_done_a),
    .core_valid_in(civ_a), .core_char_in(cci_a), .core_char_out(cco_a), .core_valid_out(cvo_a),
    .tx_start(txs_a), .tx_din(txd_a), .tx_busy(txb_a), .clr_status(clr_status),
    .overflow(ovf_a), .core_err(cerr_a), .fifo_level(lvl_a), .char_count(cnt_a), .last_rx(last_a)
  );

  punte_enigma_uart #(.ACCEPT_LOWER(0), .PASS_OTHER(1)) dut_b (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_done(rx_done_b),
    .core_valid_in(civ_b), .core_char_in(cci_b), .core_char_out(5'd0), .core_valid_out(1'b0),
    .tx_start(txs_b), .tx_din(txd_b), .tx_busy(1'b0), .clr_status(clr_status),
    .overflow(ovf_b), .core_err(cerr_b), .fifo_level(lvl_b), .char_count(cnt_b), .last_rx(last_b)
  );

  punte_enigma_uart #(.ACCEPT_LOWER(1), .PASS_OTHER(0)) dut_c (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_done(rx_done_c),
    .core_valid_in(civ_c), .core_char_in(cci_c), .core_char_out(5'd0), .core_valid_out(1'b0),
    .tx_start(txs_c), .tx_din(txd_c), .tx_busy(1'b0), .clr_status(clr_status),
    .overflow(ovf_c), .core_err(cerr_c), .fifo_level(lvl_c), .char_count(cnt_c), .last_rx(last_c)
  );

  // Core model: answers (index + core_shift) mod 26, three cycles after the request.
  logic       core_answer;
  int         core_shift;
  int         core_wait = 0;
  logic [4:0] core_res = 5'd0;
  always @(posedge clk) begin
    cvo_a <= 1'b0;
    if (core_wait > 0) begin
      core_wait <= core_wait - 1;
      if (core_wait == 1) begin
        cvo_a <= 1'b1;
        cco_a <= core_res;
      end
    end
    if (civ_a && core_answer) begin
      core_wait <= 3;
      core_res  <= 5'((int'(cci_a) + core_shift) % 26);
    end
  end

  // uart_tx model: busy for 5 cycles after tx_start, or forced high by tx_hold.
  logic tx_hold;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    if (txs_a) busy_cnt <= 5;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign txb_a = tx_hold || (busy_cnt != 0);

  // Monitors
  int         cyc = 0;
  logic [7:0] tx_log_a[$];
  int         n_civ_a = 0;
  logic [4:0] last_cci_a = 5'd0;
  int         civ_cyc = 0;
  int         seen3f_cyc = -1;
  int         n_tx_b = 0, n_civ_b = 0, n_tx_c = 0, n_civ_c = 0;
  logic [7:0] last_txd_b = 8'h00;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (txs_a) tx_log_a.push_back(txd_a);
    if (civ_a) begin
      n_civ_a    <= n_civ_a + 1;
      last_cci_a <= cci_a;
      civ_cyc    <= cyc;
    end
    if (txd_a == 8'h3F && seen3f_cyc < 0) seen3f_cyc <= cyc;
    if (txs_b) begin
      n_tx_b     <= n_tx_b + 1;
      last_txd_b <= txd_b;
    end
    if (civ_b) n_civ_b <= n_civ_b + 1;
    if (txs_c) n_tx_c <= n_tx_c + 1;
    if (civ_c) n_civ_c <= n_civ_c + 1;
  end

  task automatic send_rx(input logic [7:0] b, input int which);
    @(negedge clk);
    rx_byte = b;
    case (which)
      1:       rx_done_b = 1'b1;
      2:       rx_done_c = 1'b1;
      default: rx_done_a = 1'b1;
    endcase
    @(negedge clk);
    rx_done_a = 1'b0;
    rx_done_b = 1'b0;
    rx_done_c = 1'b0;
  endtask

  task automatic wait_cnt_a(input logic [15:0] target, input int limit);
    for (int i = 0; i < limit && cnt_a !== target; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({civ_a, txs_a, ovf_a, cerr_a} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000", {civ_a, txs_a, ovf_a, cerr_a});
    end
    checks++;
    if (txd_a !== 8'h00 || last_a !== 8'h00) begin
      errors++;
      $display("FAIL reset_bytes: tx_din=%h last_rx=%h expected 00 00", txd_a, last_a);
    end
    checks++;
    if (lvl_a !== 5'd0 || cnt_a !== 16'd0 || cci_a !== 5'd0) begin
      errors++;
      $display("FAIL reset_counts: level=%0d count=%0d char_in=%0d expected 0", lvl_a, cnt_a, cci_a);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_upper();
    int base = tx_log_a.size();
    int nciv0 = n_civ_a;
    logic [7:0] got;
    core_shift = 1;
    send_rx(8'h41, 0);
    wait_cnt_a(16'd1, 100);
    checks++;
    if (n_civ_a - nciv0 !== 1) begin
      errors++;
      $display("FAIL upper_core_strobes: got %0d expected 1", n_civ_a - nciv0);
    end
    checks++;
    if (last_cci_a !== 5'd0) begin
      errors++;
      $display("FAIL upper_char_in: got %0d expected 0", last_cci_a);
    end
    got = (tx_log_a.size() == base + 1) ? tx_log_a[base] : 8'hxx;
    checks++;
    if (got !== 8'h42) begin
      errors++;
      $display("FAIL upper_tx_din: got %h expected 42 (tx count %0d)", got, tx_log_a.size() - base);
    end
    checks++;
    if (cnt_a !== 16'd1) begin
      errors++;
      $display("FAIL upper_count: got %0d expected 1", cnt_a);
    end
  endtask

  task automatic test_lower();
    int base = tx_log_a.size();
    logic [7:0] got;
    core_shift = 14;
    send_rx(8'h71, 0);
    wait_cnt_a(16'd2, 100);
    checks++;
    if (last_cci_a !== 5'd16) begin
      errors++;
      $display("FAIL lower_char_in: got %0d expected 16", last_cci_a);
    end
    got = (tx_log_a.size() == base + 1) ? tx_log_a[base] : 8'hxx;
    checks++;
    if (got !== 8'h65) begin
      errors++;
      $display("FAIL lower_tx_din: got %h expected 65", got);
    end
    checks++;
    if (cnt_a !== 16'd2) begin
      errors++;
      $display("FAIL lower_count: got %0d expected 2", cnt_a);
    end
    // ACCEPT_LOWER=0: 'q' is passed through untouched
    send_rx(8'h71, 1);
    for (int i = 0; i < 60 && cnt_b !== 16'd1; i++) @(negedge clk);
    checks++;
    if (n_tx_b !== 1 || last_txd_b !== 8'h71) begin
      errors++;
      $display("FAIL nolower_tx: count=%0d tx_din=%h expected 1 71", n_tx_b, last_txd_b);
    end
    checks++;
    if (n_civ_b !== 0 || cnt_b !== 16'd1) begin
      errors++;
      $display("FAIL nolower_core: strobes=%0d char_count=%0d expected 0 1", n_civ_b, cnt_b);
    end
  endtask

  task automatic test_other();
    int base = tx_log_a.size();
    int nciv0 = n_civ_a;
    logic [7:0] got;
    send_rx(8'h35, 2);
    repeat (40) @(negedge clk);
    checks++;
    if (n_tx_c !== 0 || cnt_c !== 16'd0) begin
      errors++;
      $display("FAIL drop_other: tx=%0d char_count=%0d expected 0 0", n_tx_c, cnt_c);
    end
    checks++;
    if (last_c !== 8'h35 || lvl_c !== 5'd0 || n_civ_c !== 0) begin
      errors++;
      $display("FAIL drop_state: last_rx=%h level=%0d strobes=%0d expected 35 0 0", last_c, lvl_c, n_civ_c);
    end
    send_rx(8'h35, 0);
    wait_cnt_a(16'd3, 100);
    got = (tx_log_a.size() == base + 1) ? tx_log_a[base] : 8'hxx;
    checks++;
    if (got !== 8'h35 || n_civ_a !== nciv0) begin
      errors++;
      $display("FAIL pass_other: tx_din=%h strobes=%0d expected 35 0", got, n_civ_a - nciv0);
    end
  endtask

  task automatic test_backpressure();
    int base = tx_log_a.size();
    logic [7:0] got;
    core_shift = 1;
    tx_hold = 1'b1;
    for (int i = 0; i < 16; i++) send_rx(8'h41 + 8'(i), 0);
    repeat (10) @(negedge clk);
    checks++;
    if (lvl_a !== 5'd15 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_level15: level=%0d overflow=%b expected 15 0", lvl_a, ovf_a);
    end
    send_rx(8'h51, 0);
    checks++;
    if (lvl_a !== 5'd16 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: level=%0d overflow=%b expected 16 0", lvl_a, ovf_a);
    end
    // Dropped byte coincides with clr_status: the set must win.
    @(negedge clk);
    rx_byte = 8'h52;
    rx_done_a = 1'b1;
    clr_status = 1'b1;
    @(negedge clk);
    rx_done_a = 1'b0;
    clr_status = 1'b0;
    checks++;
    if (ovf_a !== 1'b1 || lvl_a !== 5'd16 || last_a !== 8'h52) begin
      errors++;
      $display("FAIL bp_overflow: overflow=%b level=%0d last_rx=%h expected 1 16 52", ovf_a, lvl_a, last_a);
    end
    checks++;
    if (tx_log_a.size() != base) begin
      errors++;
      $display("FAIL bp_held: got %0d tx_start expected 0", tx_log_a.size() - base);
    end
    tx_hold = 1'b0;
    wait_cnt_a(16'd20, 3000);
    for (int i = 0; i < 17; i++) begin
      got = (tx_log_a.size() > base + i) ? tx_log_a[base + i] : 8'hxx;
      checks++;
      if (got !== 8'h42 + 8'(i)) begin
        errors++;
        $display("FAIL bp_order[%0d]: got %h expected %h", i, got, 8'h42 + 8'(i));
      end
    end
    checks++;
    if (cnt_a !== 16'd20 || tx_log_a.size() != base + 17) begin
      errors++;
      $display("FAIL bp_count: char_count=%0d tx=%0d expected 20 17", cnt_a, tx_log_a.size() - base);
    end
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++;
    if (ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear: overflow=%b expected 0", ovf_a);
    end
  endtask

  task automatic test_timeout();
    int base = tx_log_a.size();
    logic [7:0] got;
    core_answer = 1'b0;
    send_rx(8'h43, 0);
    wait_cnt_a(16'd21, 400);
    checks++;
    if (seen3f_cyc - civ_cyc !== 256) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d expected 256", seen3f_cyc - civ_cyc);
    end
    got = (tx_log_a.size() == base + 1) ? tx_log_a[base] : 8'hxx;
    checks++;
    if (got !== 8'h3F || cerr_a !== 1'b1) begin
      errors++;
      $display("FAIL timeout_byte: tx_din=%h core_err=%b expected 3f 1", got, cerr_a);
    end
    core_answer = 1'b1;
    core_shift = 1;
    send_rx(8'h44, 0);
    wait_cnt_a(16'd22, 100);
    got = (tx_log_a.size() == base + 2) ? tx_log_a[base + 1] : 8'hxx;
    checks++;
    if (got !== 8'h45 || cerr_a !== 1'b1 || cnt_a !== 16'd22) begin
      errors++;
      $display("FAIL after_timeout: tx_din=%h core_err=%b count=%0d expected 45 1 22", got, cerr_a, cnt_a);
    end
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++;
    if (cerr_a !== 1'b0) begin
      errors++;
      $display("FAIL core_err_clear: got %b expected 0", cerr_a);
    end
  endtask

  task automatic test_reset_mid();
    int nciv0 = n_civ_a;
    int base;
    core_answer = 1'b0;
    send_rx(8'h45, 0);
    send_rx(8'h46, 0);
    for (int i = 0; i < 30 && n_civ_a == nciv0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (n_civ_a - nciv0 !== 1 || lvl_a !== 5'd1) begin
      errors++;
      $display("FAIL mid_setup: strobes=%0d level=%0d expected 1 1", n_civ_a - nciv0, lvl_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({civ_a, txs_a, ovf_a, cerr_a} !== 4'b0 || cci_a !== 5'd0) begin
      errors++;
      $display("FAIL mid_strobes: got %b char_in=%0d expected 0000 0", {civ_a, txs_a, ovf_a, cerr_a}, cci_a);
    end
    checks++;
    if (txd_a !== 8'h00 || last_a !== 8'h00 || lvl_a !== 5'd0 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL mid_regs: tx_din=%h last_rx=%h level=%0d count=%0d expected 0", txd_a, last_a, lvl_a, cnt_a);
    end
    @(negedge clk);
    rst = 1'b0;
    base = tx_log_a.size();
    repeat (300) @(negedge clk);
    checks++;
    if (tx_log_a.size() != base || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL mid_no_tx: tx=%0d count=%0d expected 0 0", tx_log_a.size() - base, cnt_a);
    end
    core_answer = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    rx_byte = 8'h00;
    rx_done_a = 1'b0;
    rx_done_b = 1'b0;
    rx_done_c = 1'b0;
    clr_status = 1'b0;
    tx_hold = 1'b0;
    core_answer = 1'b1;
    core_shift = 1;
    test_reset();
    test_upper();
    test_lower();
    test_other();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
